// File: rtl/seq_mem_rf_pkg.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// Module      : seq_mem_rf_pkg
// Description : Shared types and word-manipulation helpers for seq_mem_rf.
// Revision    : 1.0 - initial release
////////////////////////////////////////////////////////////////////////////////
package seq_mem_rf_pkg;

  // Helpers work on a wide container; callers zero-extend in and truncate out.
  // DATA_W must not exceed c_MAX_W.
  localparam int c_MAX_W     = 1024;
  localparam int c_MAX_IDX_W = $clog2(c_MAX_W);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  function automatic logic [c_MAX_W-1:0] merge_mask(
    input logic [c_MAX_W-1:0] old_word,
    input logic [c_MAX_W-1:0] data,
    input logic [c_MAX_W-1:0] mask
  );
    return (old_word & ~mask) | (data & mask);
  endfunction

  function automatic logic [c_MAX_W-1:0] set_bit(
    input logic [c_MAX_W-1:0]     word,
    input logic [c_MAX_IDX_W-1:0] idx,
    input logic                   val
  );
    logic [c_MAX_W-1:0] w_word;
    w_word      = word;
    w_word[idx] = val;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mem_rf_clear_ctrl.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// Module      : seq_mem_rf_clear_ctrl
// Description : Clear-sweep FSM; walks every entry once after reset or clr_req.
// Revision    : 1.0 - initial release
////////////////////////////////////////////////////////////////////////////////
module seq_mem_rf_clear_ctrl
  import seq_mem_rf_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b0;
    clr_en      = 1'b0;
    clr_addr    = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_en = 1'b1;
        if (r_cnt == c_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_mem_rf.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// Module      : seq_mem_rf
// Description : Register-file memory with masked write, single-bit write,
//               registered read and a self-clearing sweep.
//               SEQ_MEM_RF_BYPASS_EN: write-first read forwarding.
// Revision    : 1.0 - initial release
////////////////////////////////////////////////////////////////////////////////
module seq_mem_rf
  import seq_mem_rf_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 16,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic              bit_en,
  input  logic [ADDR_W-1:0] bit_addr,
  input  logic [BIT_W-1:0]  bit_index,
  input  logic              bit_value,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy
);

  logic                           w_clr_en;
  logic [ADDR_W-1:0]              w_clr_addr;
  logic                           w_ops_ok;
  logic                           w_wr_ok;
  logic                           w_bit_ok;
  logic                           w_rd_ok;
  logic [DEPTH-1:0][DATA_W-1:0]   w_rd_src;
  logic [DATA_W-1:0]              w_rd_word;

  seq_mem_rf_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_en   (w_clr_en),
    .clr_addr (w_clr_addr)
  );

  // A clear request wins over any access issued in the same cycle.
  assign w_ops_ok = !busy && !clr_req;
  assign w_wr_ok  = wr_en && w_ops_ok;
  assign w_bit_ok = bit_en && w_ops_ok && (32'(bit_index) < DATA_W);
  assign w_rd_ok  = rd_en && w_ops_ok;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    localparam logic [ADDR_W-1:0] c_ADDR = ADDR_W'(g);

    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_merged;

    // Masked write first, then the bit write overrides its single bit.
    always_comb begin
      w_merged = r_word;
      if (w_wr_ok && (wr_addr == c_ADDR)) begin
        w_merged = DATA_W'(merge_mask(c_MAX_W'(r_word), c_MAX_W'(wr_data),
                                      c_MAX_W'(wr_mask)));
      end
      if (w_bit_ok && (bit_addr == c_ADDR)) begin
        w_merged = DATA_W'(set_bit(c_MAX_W'(w_merged), c_MAX_IDX_W'(bit_index),
                                   bit_value));
      end
    end

    always_ff @(posedge clk) begin
      if (w_clr_en && (w_clr_addr == c_ADDR)) begin
        r_word <= INIT_VAL;
      end else begin
        r_word <= w_merged;
      end
    end

`ifdef SEQ_MEM_RF_BYPASS_EN
    assign w_rd_src[g] = w_merged;
`else
    assign w_rd_src[g] = r_word;
`endif
  end

  // Addresses beyond DEPTH match no entry and read back as zero.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        w_rd_word = w_rd_src[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        rd_data <= w_rd_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mem_rf.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// Module      : tb_seq_mem_rf
// Description : Self-checking bench for seq_mem_rf with a behavioural model.
// Revision    : 1.0 - initial release
////////////////////////////////////////////////////////////////////////////////
module tb_seq_mem_rf;

  localparam int         DP   = 16;
  localparam logic [7:0] INIT = 8'hA5;
`ifdef SEQ_MEM_RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en, bit_en, bit_value, rd_en, clr_req, rd_valid, busy;
  logic [3:0] wr_addr, bit_addr, rd_addr;
  logic [2:0] bit_index;
  logic [7:0] wr_data, wr_mask, rd_data;

  logic       b_wr_en, b_bit_en, b_bit_value, b_rd_en, b_clr_req, b_rd_valid, b_busy;
  logic [3:0] b_wr_addr, b_bit_addr, b_rd_addr;
  logic [2:0] b_bit_index;
  logic [5:0] b_wr_data, b_wr_mask, b_rd_data;

  seq_mem_rf #(.DATA_W(8), .DEPTH(16), .INIT_VAL(8'hA5)) u_dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .bit_en(bit_en), .bit_addr(bit_addr), .bit_index(bit_index), .bit_value(bit_value),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .busy(busy)
  );

  seq_mem_rf #(.DATA_W(6), .DEPTH(12), .INIT_VAL(6'h2A)) u_dut12 (
    .clk(clk), .rst(rst),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_mask(b_wr_mask),
    .bit_en(b_bit_en), .bit_addr(b_bit_addr), .bit_index(b_bit_index), .bit_value(b_bit_value),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .clr_req(b_clr_req), .busy(b_busy)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: contents, sweep cycles remaining, expected read port.
  logic [7:0] m_mem [DP];
  int         m_left;
  logic       m_valid;
  logic [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_left  = DP;
    m_valid = 1'b0;
    m_data  = 8'h00;
  endtask

  task automatic idle_in();
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_mask = 0;
    bit_en = 0; bit_addr = 0; bit_index = 0; bit_value = 0;
    rd_en = 0; rd_addr = 0; clr_req = 0;
  endtask

  task automatic b_idle_in();
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_mask = 0;
    b_bit_en = 0; b_bit_addr = 0; b_bit_index = 0; b_bit_value = 0;
    b_rd_en = 0; b_rd_addr = 0; b_clr_req = 0;
  endtask

  task automatic rand_in(input bit allow_clr);
    wr_en     = 1'($urandom_range(0, 1));
    wr_addr   = 4'($urandom);
    wr_data   = 8'($urandom);
    wr_mask   = 8'($urandom);
    bit_en    = 1'($urandom_range(0, 1));
    bit_addr  = 4'($urandom);
    bit_index = 3'($urandom);
    bit_value = 1'($urandom);
    rd_en     = 1'($urandom_range(0, 1));
    rd_addr   = 4'($urandom);
    clr_req   = allow_clr && ($urandom_range(0, 39) == 0);
  endtask

  // One clock of the main DUT: advance the model from the spec rules, compare.
  task automatic tick();
    logic [7:0] old_w;
    @(posedge clk);
    #1;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        foreach (m_mem[i]) m_mem[i] = INIT;
      end
      m_valid = 1'b0;
    end else if (clr_req) begin
      m_left  = DP;
      m_valid = 1'b0;
    end else begin
      old_w = m_mem[rd_addr];
      if (wr_en) m_mem[wr_addr] = (m_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
      if (bit_en) m_mem[bit_addr][bit_index] = bit_value;
      m_valid = rd_en;
      if (rd_en) m_data = BYPASS ? m_mem[rd_addr] : old_w;
    end
    chk("busy", busy, m_left > 0);
    chk("rd_valid", rd_valid, m_valid);
    chk("rd_data", rd_data, m_data);
  endtask

  task automatic btick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    idle_in();
    b_idle_in();
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    m_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b1);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, 8'h00);
    rst = 1'b0;

    repeat (DP) tick();
    chk("sweep_done", busy, 1'b0);

    rd_en = 1; rd_addr = 0;  tick(); chk("rd0", rd_data, 8'hA5); chk("rd0_v", rd_valid, 1'b1);
    rd_addr = 15;            tick(); chk("rd15", rd_data, 8'hA5); chk("rd15_v", rd_valid, 1'b1);
    idle_in();               tick(); chk("rd_idle_v", rd_valid, 1'b0);

    wr_en = 1; wr_addr = 3; wr_data = 8'hFF; wr_mask = 8'h0F; tick();
    idle_in(); rd_en = 1; rd_addr = 3; tick(); chk("mask_rd3", rd_data, 8'hAF);

    idle_in(); wr_en = 1; wr_addr = 5; wr_data = 8'h00; wr_mask = 8'hFF;
    bit_en = 1; bit_addr = 5; bit_index = 7; bit_value = 1; tick();
    idle_in(); rd_en = 1; rd_addr = 5; tick(); chk("bitovr_rd5", rd_data, 8'h80);

    idle_in(); wr_en = 1; wr_addr = 2; wr_data = 8'h3C; wr_mask = 8'hFF;
    rd_en = 1; rd_addr = 2; tick(); chk("rdw_rd2", rd_data, BYPASS ? 8'h3C : 8'hA5);
    idle_in(); rd_en = 1; rd_addr = 2; tick(); chk("post_rd2", rd_data, 8'h3C);

    idle_in(); clr_req = 1; wr_en = 1; wr_addr = 4; wr_data = 8'h11; wr_mask = 8'hFF;
    tick(); chk("clr_busy", busy, 1'b1);
    for (int i = 0; i < DP; i++) begin
      rand_in(1'b0);
      tick();
    end
    idle_in(); rd_en = 1; rd_addr = 4; tick(); chk("clr_rd4", rd_data, 8'hA5);

    idle_in(); clr_req = 1; tick();
    idle_in(); repeat (7) tick();
    rst = 1'b1;
    m_reset();
    #1;
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_data", rd_data, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (DP - 1) tick();
    chk("mid_rst_still_busy", busy, 1'b1);
    tick();
    chk("mid_rst_done", busy, 1'b0);
    for (int i = 0; i < DP; i++) begin
      rd_en = 1; rd_addr = 4'(i); tick();
      chk("sweep_all", rd_data, 8'hA5);
    end

    for (int i = 0; i < 500; i++) begin
      rand_in(1'b1);
      tick();
    end
    idle_in();

    k = 0;
    while (b_busy && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("b_ready", b_busy, 1'b0);
    b_wr_en = 1; b_wr_addr = 13; b_wr_data = 6'h3F; b_wr_mask = 6'h3F; btick();
    b_idle_in(); b_bit_en = 1; b_bit_addr = 1; b_bit_index = 7; b_bit_value = 0; btick();
    b_bit_addr = 2; b_bit_index = 5; btick();
    b_idle_in(); b_rd_en = 1; b_rd_addr = 13; btick();
    chk("b_oor_v", b_rd_valid, 1'b1);
    chk("b_oor_d", b_rd_data, 6'h00);
    for (int i = 0; i < 12; i++) begin
      b_rd_addr = 4'(i); btick();
      chk("b_entry", b_rd_data, (i == 2) ? 6'h0A : 6'h2A);
    end
    b_idle_in(); btick();
    chk("b_idle_v", b_rd_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_mem_rf.md
Name: seq_mem_rf

Overview:
- Parametrised register-file memory: one masked write port, one single-bit write port and one registered read port.
- Built-in clear sequencer sweeps every entry to INIT_VAL after reset or on request.
- Sits as the generic storage primitive under sequential datapath blocks, replacing ad-hoc register arrays.

Parameters:
- DATA_W, 8, entry width in bits (>=1)
- DEPTH, 16, number of entries (>=2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- INIT_VAL, '0, DATA_W-bit value written to every entry by the clear sweep

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  masked write enable
- wr_addr  in  ADDR_W  masked write address
- wr_data  in  DATA_W  write data
- wr_mask  in  DATA_W  per-bit write mask, 1 = bit updated
- bit_en  in  1  single-bit write enable
- bit_addr  in  ADDR_W  single-bit write entry address
- bit_index  in  $clog2(DATA_W) (min 1)  bit position within entry
- bit_value  in  1  bit value to write
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse, rd_data updated this cycle
- clr_req  in  1  start clear sweep (pulse)
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (async assert, any cycle, including mid-sweep): rd_data=0, rd_valid=0, busy=1, FSM=CLEAR, sweep counter=0. Memory contents are not reset directly; the sweep initialises them.
- FSM states:
  - CLEAR: writes mem[cnt]<=INIT_VAL each cycle, cnt++. After writing entry DEPTH-1, go to IDLE. A sweep lasts exactly DEPTH cycles after reset deassertion; busy drops the cycle after the last entry is written.
  - IDLE: normal operation. clr_req=1 goes to CLEAR with cnt=0 and busy=1 next cycle.
- In CLEAR: wr_en, bit_en, rd_en and clr_req are ignored; rd_valid=0; rd_data holds.
- clr_req in IDLE in the same cycle as wr_en/bit_en/rd_en: the write is dropped, the read is not performed, and the sweep starts.
- Masked write (IDLE, wr_en): mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask). Mask all-zero is a no-op.
- Bit write (IDLE, bit_en): mem[bit_addr][bit_index] <= bit_value.
- Same cycle, same address: the masked write applies first, then the bit write overrides its one bit. Different addresses: both apply independently.
- Illegal targets:
  - bit_index >= DATA_W: bit write dropped.
  - Address >= DEPTH on either write port: write dropped.
- Read (IDLE, rd_en): rd_data <= mem[rd_addr] and rd_valid=1 the next cycle (latency 1).
  - rd_addr >= DEPTH returns 0 with rd_valid=1.
  - No rd_en: rd_valid=0 and rd_data holds its last value.
- Read-during-write to the same address: returns the pre-write contents (read-first).
- Back-to-back reads are sustained, one per cycle, with no bubbles.

Optional Feature:
- Macro: SEQ_MEM_RF_BYPASS_EN.
- Defined: read-during-write returns the post-write value, including the masked merge and the bit-write override from the same cycle (write-first forwarding). Latency is unchanged.
- Undefined: read-first behaviour as specified above. No forwarding logic is generated.

Decomposition:
- Package seq_mem_rf_pkg holds:
  - state enum (ST_CLEAR, ST_IDLE)
  - function merge_mask(old, data, mask)
  - function set_bit(word, idx, val)
- Sub-module seq_mem_rf_clear_ctrl holds the FSM, the sweep counter, and the busy/clear-address/clear-enable outputs. The top level owns the array, the write merge and the read register.

Test Plan (DATA_W=8, DEPTH=16, INIT_VAL=8'hA5 unless noted):
- Reset release, then hold idle 16 cycles -> busy=1 for exactly 16 cycles; afterwards reads of addr 0 and addr 15 return 8'hA5 with rd_valid pulsing one cycle after each rd_en.
- Write addr 3, data 8'hFF, mask 8'h0F, then read 3 -> rd_data=8'hAF. In the same cycle as a write of 8'h00 mask 8'hFF to addr 5, bit write addr 5 idx 7 val 1; read 5 -> 8'h80.
- Write addr 2 = 8'h3C while rd_en addr 2 in the same cycle -> rd_data=8'hA5 (old value); with SEQ_MEM_RF_BYPASS_EN defined -> 8'h3C.
- clr_req in the same cycle as a write of 8'h11 to addr 4 -> busy for 16 cycles; read 4 afterwards returns 8'hA5. Reads and writes issued during the sweep produce no rd_valid and change no entry.
- Assert rst at sweep cycle 7 for 1 cycle, then release -> busy stays 1 for a full 16 cycles after release; all entries read 8'hA5.
- DEPTH=12: write addr 13, then read addr 13 -> rd_data=0 with rd_valid=1; addr 0..11 unchanged. bit_index 7 with DATA_W=6 -> write dropped.
